// File: rtl/bht_pkg.sv
// Shared types and helpers for the branch history table.
// Saturating counter math is done on a fixed wide word so any CTR_BITS up to CTR_W_MAX fits.
package bht_pkg;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam int CTR_W_MAX = 16;

  typedef enum logic {INIT, RUN} bht_state_e;

  function automatic logic [CTR_W_MAX-1:0] sat_update(
    input logic [CTR_W_MAX-1:0] ctr,
    input logic                 taken,
    input int unsigned          bits
  );
    logic [CTR_W_MAX-1:0] top;
    top = CTR_W_MAX'((33'd1 << bits) - 33'd1);
    if (taken) begin
      sat_update = (ctr >= top) ? top : ctr + CTR_W_MAX'(1);
    end else begin
      sat_update = (ctr == '0) ? ctr : ctr - CTR_W_MAX'(1);
    end
  endfunction
endpackage

// File: rtl/bht_predictor_if.sv
// Lookup/update/status bundle between fetch+execute (master) and the predictor (slave).
// Same-cycle combinational lookup, no back-pressure on updates.
interface bht_predictor_if #(
  parameter int IDX_W  = 6,
  parameter int MISS_W = 16
);
  logic [31:0]       lookup_pc;
  logic [31:0]       Instruction_code;
  logic              Prediction;
  logic [IDX_W-1:0]  lookup_ghr;
  logic              update_valid;
  logic [31:0]       update_pc;
  logic              update_taken;
  logic              update_pred;
  logic [IDX_W-1:0]  update_ghr;
  logic              ready;
  logic [MISS_W-1:0] miss_count;

  modport master (
    output lookup_pc, Instruction_code, update_valid, update_pc,
           update_taken, update_pred, update_ghr,
    input  Prediction, lookup_ghr, ready, miss_count
  );

  modport slave (
    input  lookup_pc, Instruction_code, update_valid, update_pc,
           update_taken, update_pred, update_ghr,
    output Prediction, lookup_ghr, ready, miss_count
  );
endinterface

// File: rtl/bht_sat_ctr_bank.sv
// Counter storage: one write port (init value or saturating update) and one async read port.
// The write port reads its own entry internally, so update and lookup never contend.
module bht_sat_ctr_bank
  import bht_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic                wr_init,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_taken,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CTR_BITS-1:0] rd_ctr
);
  localparam logic [CTR_BITS-1:0] WT = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [CTR_BITS-1:0]  mem [ENTRIES];
  logic [CTR_W_MAX-1:0] upd_wide;

  assign upd_wide = sat_update(CTR_W_MAX'(mem[wr_idx]), wr_taken, CTR_BITS);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_init ? WT : upd_wide[CTR_BITS-1:0];
    end
  end

  assign rd_ctr = mem[rd_idx];
endmodule

// File: rtl/bht_predictor.sv
// Branch history table with post-reset init walk and saturating mispredict counter.
// Optional gshare indexing via macro BHT_GSHARE_EN.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int ENTRIES  = 64,
  parameter int CTR_BITS = 2,
  parameter int MISS_W   = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input logic            clk,
  input logic            reset,
  bht_predictor_if.slave bus
);
  bht_state_e          state_q, state_d;
  logic [IDX_W-1:0]    init_idx_q, init_idx_d;
  logic [MISS_W-1:0]   miss_q;
  logic                run_upd;
  logic                wr_en, wr_init;
  logic [IDX_W-1:0]    wr_idx, lookup_idx, update_idx;
  logic [CTR_BITS-1:0] rd_ctr;

`ifdef BHT_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (run_upd) begin
      ghr_q <= IDX_W'({ghr_q, bus.update_taken});
    end
  end

  assign lookup_idx     = bus.lookup_pc[IDX_W+1:2] ^ ghr_q;
  assign update_idx     = bus.update_pc[IDX_W+1:2] ^ bus.update_ghr;
  assign bus.lookup_ghr = ghr_q;
`else
  assign lookup_idx     = bus.lookup_pc[IDX_W+1:2];
  assign update_idx     = bus.update_pc[IDX_W+1:2];
  assign bus.lookup_ghr = '0;
`endif

  assign run_upd = (state_q == RUN) && bus.update_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      if (run_upd && (bus.update_pred != bus.update_taken) && !(&miss_q)) begin
        miss_q <= miss_q + MISS_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wr_en      = 1'b0;
    wr_init    = 1'b0;
    wr_idx     = update_idx;
    bus.ready  = 1'b0;
    case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_init    = 1'b1;
        wr_idx     = init_idx_q;
        init_idx_d = init_idx_q + IDX_W'(1);
        if (init_idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        bus.ready = 1'b1;
        wr_en     = bus.update_valid;
      end
      default: state_d = INIT;
    endcase
  end

  bht_sat_ctr_bank #(
    .ENTRIES  (ENTRIES),
    .CTR_BITS (CTR_BITS)
  ) u_bank (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_init  (wr_init),
    .wr_idx   (wr_idx),
    .wr_taken (bus.update_taken),
    .rd_idx   (lookup_idx),
    .rd_ctr   (rd_ctr)
  );

  assign bus.Prediction = rd_ctr[CTR_BITS-1] & (bus.Instruction_code[6:0] == OPC_BRANCH) & bus.ready;
  assign bus.miss_count = miss_q;
endmodule
